// File: rtl/buffer_seq_ctrl_if.sv
// Control and status bundle between the layer-pass sequencer, its requester
// and the tapped delay buffer it steers.
interface buffer_seq_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [2:0]       layer;
  logic [CNT_W-1:0] num_samples;
  logic             abort;
  logic [1:0]       s5;
  logic [1:0]       s6;
  logic             feed_en;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, layer, num_samples, abort,
    input  s5, s6, feed_en, out_valid, busy, done, err
  );

  modport slave (
    input  start, layer, num_samples, abort,
    output s5, s6, feed_en, out_valid, busy, done, err
  );
endinterface

// File: rtl/buffer_seq_ctrl.sv
// Sequencer for one layer pass through a tapped delay buffer: selects the tap,
// gates sample feeding and flags the window where delayed samples are valid.
module buffer_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  buffer_seq_ctrl_if.slave bus
);
  localparam int CW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] s5;
    logic [1:0] s6;
    logic [5:0] lat;
  } layer_cfg_t;

  // LAT is the tap index plus three: shift stage, tap register, output register.
  function automatic layer_cfg_t decode_layer(input logic [2:0] code);
    layer_cfg_t cfg;
    cfg = '{legal: 1'b1, s5: 2'b00, s6: 2'b00, lat: 6'd0};
    case (code)
      3'd0:    begin cfg.s5 = 2'b00; cfg.s6 = 2'b00; cfg.lat = 6'd23; end
      3'd1:    begin cfg.s5 = 2'b01; cfg.s6 = 2'b00; cfg.lat = 6'd38; end
      3'd2:    begin cfg.s5 = 2'b10; cfg.s6 = 2'b00; cfg.lat = 6'd56; end
      3'd3:    begin cfg.s5 = 2'b00; cfg.s6 = 2'b01; cfg.lat = 6'd8;  end
      3'd4:    begin cfg.s5 = 2'b00; cfg.s6 = 2'b10; cfg.lat = 6'd20; end
      3'd5:    begin cfg.s5 = 2'b00; cfg.s6 = 2'b11; cfg.lat = 6'd23; end
      default: cfg.legal = 1'b0;
    endcase
    return cfg;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] n_q, n_d;
  logic [5:0]    lat_q, lat_d;
  logic [1:0]    s5_q, s5_d, s6_q, s6_d;
  logic          feed_en_q, feed_en_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  layer_cfg_t    cfg;
  logic [CW-1:0] last_cyc;
  logic [CW-1:0] win_lo, win_hi;

  assign cfg      = decode_layer(bus.layer);
  assign last_cyc = CW'(lat_q) + n_q - CW'(1);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    n_d     = n_q;
    lat_d   = lat_q;
    s5_d    = s5_q;
    s6_d    = s6_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here, so start wins when both are high.
        if (bus.start) begin
          if (!cfg.legal) begin
            err_d = 1'b1;
          end else begin
            s5_d = cfg.s5;
            s6_d = cfg.s6;
            if (bus.num_samples == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              cyc_d   = '0;
              n_d     = CW'(bus.num_samples);
              lat_d   = cfg.lat;
            end
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (cyc_q == last_cyc) begin
          state_d = FINISH;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next-state values.
  assign win_lo = CW'(lat_d);
  assign win_hi = CW'(lat_d) + n_d;

  always_comb begin
    feed_en_d   = (state_d == RUN) && (cyc_d < n_d);
    out_valid_d = (state_d == RUN) && (cyc_d >= win_lo) && (cyc_d < win_hi);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      n_q         <= '0;
      lat_q       <= '0;
      s5_q        <= 2'b00;
      s6_q        <= 2'b00;
      feed_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      n_q         <= n_d;
      lat_q       <= lat_d;
      s5_q        <= s5_d;
      s6_q        <= s6_d;
      feed_en_q   <= feed_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.s5        = s5_q;
  assign bus.s6        = s6_q;
  assign bus.feed_en   = feed_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Directed bench for buffer_seq_ctrl with a small tapped-delay-buffer model
// fed under feed_en and tapped by s5/s6.
module tb_buffer_seq_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  int total = 0;
  int bad = 0;

  buffer_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
  buffer_seq_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Delay buffer model: shift stage, tap register, output register.
  logic [7:0] shift_reg [0:63];
  logic [7:0] tap_q = 8'h00;
  logic [7:0] buf_out = 8'h00;

  function automatic int tap_of(input logic [1:0] s5, input logic [1:0] s6);
    case ({s6, s5})
      4'b00_00: return 20;
      4'b00_01: return 35;
      4'b00_10: return 53;
      4'b01_00: return 5;
      4'b10_00: return 17;
      4'b11_00: return 20;
      default:  return 0;
    endcase
  endfunction

  initial for (int i = 0; i < 64; i++) shift_reg[i] = 8'h00;

  always @(posedge clk) begin
    shift_reg[0] <= bus.feed_en ? data_in : 8'h00;
    for (int i = 1; i < 64; i++) shift_reg[i] <= shift_reg[i-1];
    tap_q   <= shift_reg[tap_of(bus.s5, bus.s6)];
    buf_out <= tap_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] layer, input int n);
    bus.layer = layer;
    bus.num_samples = CNT_W'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.layer = 3'd0; bus.num_samples = '0;
    #12;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.feed_en !== 1'b0) begin bad++; $display("FAIL reset_feed got=%b exp=0", bus.feed_en); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", bus.out_valid); end
    total++; if ({bus.done, bus.err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b exp=00", {bus.done, bus.err}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b exp=0000", {bus.s5, bus.s6}); end
    #1 rst = 1'b1;
  endtask

  // layer 3, N=4: LAT=8, feed cycles 0-3, valid cycles 8-11, done after cycle 11.
  task automatic test_layer3();
    launch(3'd3, 4);
    total++; if ({bus.s5, bus.s6} !== 4'b0001) begin bad++; $display("FAIL l3_sel got=%b exp=0001", {bus.s5, bus.s6}); end
    for (int c = 0; c < 12; c++) begin
      total++; if (bus.feed_en !== (c < 4)) begin bad++; $display("FAIL l3_feed c=%0d got=%b exp=%b", c, bus.feed_en, c < 4); end
      total++; if (bus.out_valid !== (c >= 8 && c < 12)) begin bad++; $display("FAIL l3_ovalid c=%0d got=%b exp=%b", c, bus.out_valid, c >= 8); end
      total++; if ({bus.busy, bus.done} !== 2'b10) begin bad++; $display("FAIL l3_busy_done c=%0d got=%b exp=10", c, {bus.busy, bus.done}); end
      if (c == 2) begin
        // start while busy must be ignored
        bus.layer = 3'd2; bus.num_samples = 16'd1; bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    total++; if ({bus.busy, bus.done, bus.feed_en, bus.out_valid} !== 4'b1100) begin bad++; $display("FAIL l3_finish got=%b exp=1100", {bus.busy, bus.done, bus.feed_en, bus.out_valid}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0001) begin bad++; $display("FAIL l3_sel_finish got=%b exp=0001", {bus.s5, bus.s6}); end
    tick();
    total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL l3_idle got=%b exp=00", {bus.busy, bus.done}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0001) begin bad++; $display("FAIL l3_sel_idle got=%b exp=0001", {bus.s5, bus.s6}); end
  endtask

  // layer 2, N=1: tap 53, LAT=56, the single fed sample reappears at cycle 56.
  task automatic test_layer2();
    launch(3'd2, 1);
    data_in = 8'hA5;
    total++; if ({bus.s5, bus.s6} !== 4'b1000) begin bad++; $display("FAIL l2_sel got=%b exp=1000", {bus.s5, bus.s6}); end
    for (int c = 0; c <= 56; c++) begin
      total++; if (bus.feed_en !== (c == 0)) begin bad++; $display("FAIL l2_feed c=%0d got=%b exp=%b", c, bus.feed_en, c == 0); end
      total++; if (bus.out_valid !== (c == 56)) begin bad++; $display("FAIL l2_ovalid c=%0d got=%b exp=%b", c, bus.out_valid, c == 56); end
      if (c == 56) begin
        total++; if (buf_out !== 8'hA5) begin bad++; $display("FAIL l2_data got=%h exp=a5", buf_out); end
      end
      tick();
      data_in = 8'h3C;
    end
    total++; if ({bus.busy, bus.done} !== 2'b11) begin bad++; $display("FAIL l2_done got=%b exp=11", {bus.busy, bus.done}); end
    tick();
  endtask

  task automatic test_illegal();
    launch(3'd7, 5);
    total++; if ({bus.err, bus.busy} !== 2'b10) begin bad++; $display("FAIL ill_err got=%b exp=10", {bus.err, bus.busy}); end
    total++; if ({bus.s5, bus.s6} !== 4'b1000) begin bad++; $display("FAIL ill_sel got=%b exp=1000", {bus.s5, bus.s6}); end
    tick();
    total++; if ({bus.err, bus.busy, bus.done} !== 3'b000) begin bad++; $display("FAIL ill_after got=%b exp=000", {bus.err, bus.busy, bus.done}); end
  endtask

  task automatic test_zero_samples();
    launch(3'd0, 0);
    total++; if ({bus.done, bus.busy, bus.feed_en, bus.out_valid} !== 4'b1000) begin bad++; $display("FAIL zero_done got=%b exp=1000", {bus.done, bus.busy, bus.feed_en, bus.out_valid}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0000) begin bad++; $display("FAIL zero_sel got=%b exp=0000", {bus.s5, bus.s6}); end
    tick();
    total++; if ({bus.done, bus.busy, bus.feed_en, bus.out_valid} !== 4'b0000) begin bad++; $display("FAIL zero_after got=%b exp=0000", {bus.done, bus.busy, bus.feed_en, bus.out_valid}); end
  endtask

  task automatic test_abort();
    launch(3'd4, 10);
    total++; if ({bus.s5, bus.s6} !== 4'b0010) begin bad++; $display("FAIL ab_sel got=%b exp=0010", {bus.s5, bus.s6}); end
    for (int c = 0; c <= 15; c++) begin
      total++; if (bus.feed_en !== (c < 10)) begin bad++; $display("FAIL ab_feed c=%0d got=%b exp=%b", c, bus.feed_en, c < 10); end
      if (c == 15) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    total++; if ({bus.busy, bus.done, bus.feed_en, bus.out_valid} !== 4'b0000) begin bad++; $display("FAIL ab_idle got=%b exp=0000", {bus.busy, bus.done, bus.feed_en, bus.out_valid}); end
    // restart immediately, with abort held high alongside start
    bus.abort = 1'b1;
    launch(3'd1, 3);
    bus.abort = 1'b0;
    total++; if ({bus.busy, bus.feed_en} !== 2'b11) begin bad++; $display("FAIL ab_restart got=%b exp=11", {bus.busy, bus.feed_en}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0100) begin bad++; $display("FAIL ab_restart_sel got=%b exp=0100", {bus.s5, bus.s6}); end
    bus.abort = 1'b1;
    tick();
    total++; if ({bus.busy, bus.done, bus.feed_en} !== 3'b000) begin bad++; $display("FAIL ab_second got=%b exp=000", {bus.busy, bus.done, bus.feed_en}); end
    tick();  // abort while idle
    bus.abort = 1'b0;
    total++; if ({bus.busy, bus.done, bus.s5, bus.s6} !== 6'b000100) begin bad++; $display("FAIL ab_in_idle got=%b exp=000100", {bus.busy, bus.done, bus.s5, bus.s6}); end
  endtask

  task automatic test_async_reset();
    launch(3'd5, 8);
    total++; if ({bus.s5, bus.s6} !== 4'b0011) begin bad++; $display("FAIL ar_sel got=%b exp=0011", {bus.s5, bus.s6}); end
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    total++; if ({bus.busy, bus.feed_en, bus.out_valid, bus.done, bus.err} !== 5'b00000) begin bad++; $display("FAIL ar_flags got=%b exp=00000", {bus.busy, bus.feed_en, bus.out_valid, bus.done, bus.err}); end
    total++; if ({bus.s5, bus.s6} !== 4'b0000) begin bad++; $display("FAIL ar_sel_zero got=%b exp=0000", {bus.s5, bus.s6}); end
    #3 rst = 1'b1;
    launch(3'd3, 4);
    total++; if ({bus.busy, bus.feed_en, bus.s5, bus.s6} !== 6'b110001) begin bad++; $display("FAIL ar_first_start got=%b exp=110001", {bus.busy, bus.feed_en, bus.s5, bus.s6}); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_layer3();
    test_layer2();
    test_illegal();
    test_zero_samples();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_seq_ctrl.md
BUFFER_SEQ_CTRL -- requirements
Module: buffer_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the sample count and cycle counter.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port start  input  1  single-cycle pulse that launches one layer pass.
REQ-005 The block SHALL have port layer  input  3  layer code, sampled with start.
REQ-006 The block SHALL have port num_samples  input  CNT_W  sample count for the pass, sampled with start.
REQ-007 The block SHALL have port abort  input  1  synchronous cancel of the current pass.
REQ-008 The block SHALL have port s5  output  2  small-mux select to the tapped delay buffer.
REQ-009 The block SHALL have port s6  output  2  final-mux select to the tapped delay buffer.
REQ-010 The block SHALL have port feed_en  output  1  high on every cycle the upstream drives a valid sample into the buffer.
REQ-011 The block SHALL have port out_valid  output  1  high on every cycle the buffer output holds a valid delayed sample.
REQ-012 The block SHALL have port busy  output  1  high while a pass is in progress.
REQ-013 The block SHALL have port done  output  1  single-cycle pulse at pass completion.
REQ-014 The block SHALL have port err  output  1  single-cycle pulse on an illegal layer code at start.

Function
REQ-015 The layer table SHALL map code to (s5, s6, LAT) as follows: 0->(00,00,23); 1->(01,00,38); 2->(10,00,56); 3->(00,01,8); 4->(00,10,20); 5->(00,11,23).
- LAT = tap index + 3, covering the shift stage, the tap register and the output register.
REQ-016 The FSM SHALL have the states IDLE, RUN and FINISH.
REQ-017 In IDLE, start with a legal code and num_samples > 0 SHALL latch layer and N and load s5/s6 on the same edge; the next state SHALL be RUN with cyc = 0.
REQ-018 In IDLE, start with layer 6 or 7 SHALL pulse err for one cycle, leave the FSM in IDLE and leave s5/s6 unchanged.
REQ-019 In IDLE, start with a legal code and num_samples = 0 SHALL load s5/s6 and pulse done on the next cycle without entering RUN; feed_en and out_valid SHALL stay low.
REQ-020 In RUN, cyc SHALL increment by 1 per cycle, with feed_en = (cyc < N) and out_valid = (LAT <= cyc < LAT+N).
- All comparisons are unsigned on CNT_W+1 bits, so LAT+N cannot wrap.
REQ-021 When cyc = LAT+N-1 in RUN, the next state SHALL be FINISH; FINISH SHALL pulse done for one cycle and then return to IDLE.
REQ-022 busy SHALL be high in RUN and FINISH and low in IDLE.
REQ-023 start SHALL be ignored while busy.
REQ-024 s5 and s6 SHALL hold stable from load until the next accepted start, including through FINISH and IDLE.
REQ-025 abort in RUN or FINISH SHALL force IDLE on the next edge, drive feed_en and out_valid low from that edge, and suppress done.
REQ-026 abort in IDLE SHALL have no effect.
REQ-027 If abort and start are asserted together in IDLE, start SHALL be accepted.
REQ-028 All outputs SHALL be registered; feed_en SHALL first rise on the cycle after the start edge.

Reset
REQ-029 While rst = 0, the FSM SHALL be in IDLE with cyc = 0 and s5 = 00, s6 = 00, feed_en = 0, out_valid = 0, busy = 0, done = 0, err = 0.
REQ-030 Reset asserted mid-pass SHALL take effect asynchronously.
REQ-031 After reset is released, the first rising edge SHALL accept start.

Verification
REQ-032 The bench SHALL cover: layer=3, N=4 -> s6=01, s5=00; feed_en high for cycles 0-3 of RUN; out_valid high for cycles 8-11; done one cycle after cycle 11.
REQ-033 The bench SHALL cover: layer=2, N=1 -> s5=10; out_valid high only at cyc 56; a buffer output equal to the fed value on that cycle.
REQ-034 The bench SHALL cover: layer=7 -> err pulses once, busy stays 0, s5/s6 keep their prior values.
REQ-035 The bench SHALL cover: layer=0, N=0 -> s5=00, s6=00; done pulses on the next cycle; feed_en/out_valid never high.
REQ-036 The bench SHALL cover: layer=4, N=10, abort at cyc 15 -> IDLE next cycle, no done pulse, and a second start accepted immediately afterwards.
REQ-037 The bench SHALL cover: layer=5, N=8, rst low at cyc 5 -> all outputs zero immediately, with no clock edge required.
